// File: rtl/imsic_pkg.sv
// Shared types and sizing helpers for the IMSIC interrupt file.
package imsic_pkg;

    localparam int unsigned WordBits = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    function automatic int unsigned nr_words(input int unsigned nr_sources);
        return nr_sources / WordBits;
    endfunction

endpackage

// File: rtl/imsic_prio_word.sv
// Lowest-set-bit finder for one 32-bit candidate word; lower bit wins.
module imsic_prio_word
    import imsic_pkg::*;
(
    input  logic [WordBits-1:0] i_word,
    output logic                o_hit,
    output logic [4:0]          o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = WordBits - 1; k >= 0; k--) begin
            if (i_word[k]) begin
                o_hit = 1'b1;
                o_idx = 5'(k);
            end
        end
    end

endmodule

// File: rtl/imsic_intr_file.sv
// IMSIC interrupt file: eip/eie arrays plus a word-serial scan that
// produces the top pending-and-enabled identity (topei) and the hart irq.
//
// state | meaning
// IDLE  | result current, waiting for a change event
// SCAN  | examining candidate word word_q
// DONE  | result just latched, topei valid
module imsic_intr_file
    import imsic_pkg::*;
#(
    parameter int unsigned NrSources  = 64,
    parameter int unsigned NrSourcesW = $clog2(NrSources)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NrSourcesW-1:0]   i_setipnum,
    input  logic                    i_setipnum_we,
    input  logic                    i_delivery_en,
    input  logic [NrSourcesW-1:0]   i_threshold,
    input  logic                    i_eie_we,
    input  logic [NrSourcesW-6:0]   i_eie_idx,
    input  logic [31:0]             i_eie_wdata,
    input  logic                    i_claim,
    output logic [NrSourcesW-1:0]   o_topei,
    output logic                    o_topei_valid,
    output logic                    o_irq
);

    localparam int unsigned NrWords  = nr_words(NrSources);
    localparam int unsigned WordIdxW = NrSourcesW - 5;
    localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(NrWords - 1);

    logic [NrSources-1:0]  eip_q, eip_d;
    logic [NrSources-1:0]  eie_q, eie_d;
    logic [NrSources-1:0]  cand;
    logic [NrSourcesW-1:0] thr_q, thr_d;
    logic [NrSourcesW-1:0] topei_q, topei_d;
    logic [WordIdxW-1:0]   word_q, word_d;
    scan_state_e           state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  irq_q, irq_d;
    logic                  start_q, start_d;

    logic                  set_ok, eie_ok, claim_ok, thr_chg, chg;
    logic [WordBits-1:0]   cand_word;
    logic                  hit;
    logic [4:0]            hit_idx;

    always_comb begin
        set_ok   = i_setipnum_we && (i_setipnum != '0)
                   && ({1'b0, i_setipnum} < (NrSourcesW+1)'(NrSources));
        eie_ok   = i_eie_we && ({1'b0, i_eie_idx} < (WordIdxW+1)'(NrWords));
        claim_ok = i_claim && valid_q && (topei_q != '0);
        thr_chg  = (i_threshold != thr_q);
        chg      = set_ok || eie_ok || claim_ok || thr_chg || start_q;
    end

    // Claim is applied before set so a same-cycle set of the same identity wins.
    always_comb begin
        eip_d = eip_q;
        eie_d = eie_q;
        if (claim_ok) begin
            eip_d[topei_q] = 1'b0;
        end
        if (set_ok) begin
            eip_d[i_setipnum] = 1'b1;
        end
        if (eie_ok) begin
            eie_d[i_eie_idx*WordBits +: WordBits] = i_eie_wdata;
        end
        eip_d[0] = 1'b0;
        eie_d[0] = 1'b0;
        thr_d    = i_threshold;
        start_d  = 1'b0;
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NrSources; i++) begin
            cand[i] = eip_q[i] & eie_q[i]
                      & ((i_threshold == '0) || (NrSourcesW'(i) < i_threshold));
        end
        cand_word = cand[word_q*WordBits +: WordBits];
    end

    imsic_prio_word u_prio_word (
        .i_word (cand_word),
        .o_hit  (hit),
        .o_idx  (hit_idx)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        topei_d = topei_q;
        valid_d = valid_q;
        if (chg) begin
            state_d = ST_SCAN;
            word_d  = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_SCAN: begin
                    if (hit || (word_q == LastWord)) begin
                        state_d = ST_DONE;
                        topei_d = hit ? {word_q, hit_idx} : '0;
                        valid_d = 1'b1;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        irq_d = i_delivery_en && valid_d && (topei_d != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            eip_q   <= '0;
            eie_q   <= '0;
            thr_q   <= '0;
            topei_q <= '0;
            word_q  <= '0;
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
            start_q <= 1'b1;
        end else begin
            eip_q   <= eip_d;
            eie_q   <= eie_d;
            thr_q   <= thr_d;
            topei_q <= topei_d;
            word_q  <= word_d;
            state_q <= state_d;
            valid_q <= valid_d;
            irq_q   <= irq_d;
            start_q <= start_d;
        end
    end

    assign o_topei       = topei_q;
    assign o_topei_valid = valid_q;
    assign o_irq         = irq_q;

endmodule
